shop_client: RTL and testbench

Transaction initiator for the shop command interface. A single `i_start` pulse selects one operation (login, add user, buy, …). The block then drives the shop's command side as a sequence of one-cycle ASCII words with an `rdy` strobe, samples the shop's ASCII reply after a fixed latency, and checks each reply against the expected prompt. It returns one `o_done` pulse carrying a decoded status code. It sits between a host/scenario controller and the shop block: its `o_a`/`o_rdy`/`o_u` feed the shop's `i_a`/`i_rdy`/`i_u`, and the shop's `o_a` feeds its `i_a`.

---
 rtl/shop_pkg.sv | 102 ++++++++++
 rtl/shop_resp_decode.sv | 34 +++
 rtl/shop_client.sv | 153 +++++++++++++++
 tb/tb_shop_client.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/shop_pkg.sv
// rtl/shop_pkg.sv - shared widths, opcodes, status codes and ASCII strings for the shop client
package shop_pkg;

   localparam int O_A_NUM_BITS = 56;
   localparam int I_A_NUM_BITS = 72;
   localparam int U_NUM_BITS   = 4;

   localparam logic [2:0] OP_LOGOUT   = 3'd0;
   localparam logic [2:0] OP_LOGIN    = 3'd1;
   localparam logic [2:0] OP_ADD_USER = 3'd2;
   localparam logic [2:0] OP_DEL_USER = 3'd3;
   localparam logic [2:0] OP_ADD_ITEM = 3'd4;
   localparam logic [2:0] OP_DEL_ITEM = 3'd5;
   localparam logic [2:0] OP_BUY      = 3'd6;
   localparam logic [2:0] OP_RSVD     = 3'd7;

   localparam logic [3:0] ST_OK          = 4'd0;
   localparam logic [3:0] ST_INVAL_CMD   = 4'd1;
   localparam logic [3:0] ST_INVAL_PERM  = 4'd2;
   localparam logic [3:0] ST_USR_UNKNWN  = 4'd3;
   localparam logic [3:0] ST_USR_TAKEN   = 4'd4;
   localparam logic [3:0] ST_NO_DEL_ADMN = 4'd5;
   localparam logic [3:0] ST_ITMS_FULL   = 4'd6;
   localparam logic [3:0] ST_ITM_EXISTS  = 4'd7;
   localparam logic [3:0] ST_ITM_UNKNWN  = 4'd8;
   localparam logic [3:0] ST_NT_YOUR_ITM = 4'd9;
   localparam logic [3:0] ST_NO_STOCK    = 4'd10;
   localparam logic [3:0] ST_BAD_OP      = 4'd14;
   localparam logic [3:0] ST_BAD_RESP    = 4'd15;

   localparam logic [O_A_NUM_BITS-1:0] C_LOGOUT   = 56'("Logout");
   localparam logic [O_A_NUM_BITS-1:0] C_LOGIN    = 56'("Login");
   localparam logic [O_A_NUM_BITS-1:0] C_ADD_USER = 56'("AddUsr");
   localparam logic [O_A_NUM_BITS-1:0] C_DEL_USER = 56'("DelUsr");
   localparam logic [O_A_NUM_BITS-1:0] C_ADD_ITEM = 56'("AddItem");
   localparam logic [O_A_NUM_BITS-1:0] C_DEL_ITEM = 56'("DelItem");
   localparam logic [O_A_NUM_BITS-1:0] C_BUY      = 56'("Buy");

   localparam logic [I_A_NUM_BITS-1:0] S_CMD        = 72'("Cmd?");
   localparam logic [I_A_NUM_BITS-1:0] S_USRNAME    = 72'("Usrname?");
   localparam logic [I_A_NUM_BITS-1:0] S_PASSWD     = 72'("Passwd?");
   localparam logic [I_A_NUM_BITS-1:0] S_PERMS      = 72'("Perms?");
   localparam logic [I_A_NUM_BITS-1:0] S_USRDELETD  = 72'("UsrDeletd");
   localparam logic [I_A_NUM_BITS-1:0] S_ITMNAME    = 72'("ItmName?");
   localparam logic [I_A_NUM_BITS-1:0] S_STOCK      = 72'("Stock?");
   localparam logic [I_A_NUM_BITS-1:0] S_ITMADDED   = 72'("ItmAdded");
   localparam logic [I_A_NUM_BITS-1:0] S_ITMDELETD  = 72'("ItmDeletd");
   localparam logic [I_A_NUM_BITS-1:0] S_ITMBOUGHT  = 72'("ItmBought");
   localparam logic [I_A_NUM_BITS-1:0] S_INVALCMD   = 72'("InvalCmd");
   localparam logic [I_A_NUM_BITS-1:0] S_INVALPERM  = 72'("InvalPerm");
   localparam logic [I_A_NUM_BITS-1:0] S_USRUNKNWN  = 72'("UsrUnknwn");
   localparam logic [I_A_NUM_BITS-1:0] S_USRTAKEN   = 72'("UsrTaken");
   localparam logic [I_A_NUM_BITS-1:0] S_NODELADMN  = 72'("NoDelAdmn");
   localparam logic [I_A_NUM_BITS-1:0] S_ITMSFULL   = 72'("ItmsFull");
   localparam logic [I_A_NUM_BITS-1:0] S_ITMEXISTS  = 72'("ItmExists");
   localparam logic [I_A_NUM_BITS-1:0] S_ITMUNKNWN  = 72'("ItmUnknwn");
   localparam logic [I_A_NUM_BITS-1:0] S_NTYOURITM  = 72'("NtYourItm");
   localparam logic [I_A_NUM_BITS-1:0] S_NOSTOCK    = 72'("NoStock");

   typedef enum logic [3:0] {
      R_CMD, R_USRNAME, R_PASSWD, R_PERMS, R_USRDELETD,
      R_ITMNAME, R_STOCK, R_ITMADDED, R_ITMDELETD, R_ITMBOUGHT
   } reply_e;

   typedef enum logic [2:0] {W_CMD, W_USER, W_PASS, W_ITEM, W_PERMS, W_STOCK} word_e;

   typedef struct packed {
      word_e  word;
      reply_e resp;
      logic   last;
   } step_t;

   function automatic logic [I_A_NUM_BITS-1:0] reply_str(input reply_e r);
      case (r)
         R_CMD:       return S_CMD;
         R_USRNAME:   return S_USRNAME;
         R_PASSWD:    return S_PASSWD;
         R_PERMS:     return S_PERMS;
         R_USRDELETD: return S_USRDELETD;
         R_ITMNAME:   return S_ITMNAME;
         R_STOCK:     return S_STOCK;
         R_ITMADDED:  return S_ITMADDED;
         R_ITMDELETD: return S_ITMDELETD;
         R_ITMBOUGHT: return S_ITMBOUGHT;
         default:     return '0;
      endcase
   endfunction

   function automatic logic [O_A_NUM_BITS-1:0] cmd_str(input logic [2:0] op);
      case (op)
         OP_LOGOUT:   return C_LOGOUT;
         OP_LOGIN:    return C_LOGIN;
         OP_ADD_USER: return C_ADD_USER;
         OP_DEL_USER: return C_DEL_USER;
         OP_ADD_ITEM: return C_ADD_ITEM;
         OP_DEL_ITEM: return C_DEL_ITEM;
         OP_BUY:      return C_BUY;
         default:     return '0;
      endcase
   endfunction

endpackage

// File: rtl/shop_resp_decode.sv
// rtl/shop_resp_decode.sv - compares a shop reply with the expected prompt and decodes error replies
module shop_resp_decode
   import shop_pkg::*;
(
   input  logic [I_A_NUM_BITS-1:0] reply,
   input  logic [3:0]              expect_idx,
   output logic                    match,
   output logic [3:0]              status
);

   always_comb begin
      match = (reply == reply_str(reply_e'(expect_idx)));
      status = ST_BAD_RESP;
      if (match) begin
         status = ST_OK;
      end else begin
         // Known prompts arriving at the wrong step fall through to BAD_RESP.
         case (reply)
            S_INVALCMD:  status = ST_INVAL_CMD;
            S_INVALPERM: status = ST_INVAL_PERM;
            S_USRUNKNWN: status = ST_USR_UNKNWN;
            S_USRTAKEN:  status = ST_USR_TAKEN;
            S_NODELADMN: status = ST_NO_DEL_ADMN;
            S_ITMSFULL:  status = ST_ITMS_FULL;
            S_ITMEXISTS: status = ST_ITM_EXISTS;
            S_ITMUNKNWN: status = ST_ITM_UNKNWN;
            S_NTYOURITM: status = ST_NT_YOUR_ITM;
            S_NOSTOCK:   status = ST_NO_STOCK;
            default:     status = ST_BAD_RESP;
         endcase
      end
   end

endmodule

// File: rtl/shop_client.sv
// rtl/shop_client.sv - issues one shop transaction per start and reports a decoded status
module shop_client
   import shop_pkg::*;
#(
   parameter int RESP_LAT = 3
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic [2:0]              i_op,
   input  logic [O_A_NUM_BITS-1:0] i_user,
   input  logic [O_A_NUM_BITS-1:0] i_pass,
   input  logic [O_A_NUM_BITS-1:0] i_item,
   input  logic [U_NUM_BITS-1:0]   i_perms,
   input  logic [U_NUM_BITS-1:0]   i_stock,
   output logic [O_A_NUM_BITS-1:0] o_a,
   output logic                    o_rdy,
   output logic [U_NUM_BITS-1:0]   o_u,
   input  logic [I_A_NUM_BITS-1:0] i_a,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [3:0]              o_status
);

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_CHECK, S_DONE} state_e;

   state_e                  state, state_nx;
   logic [2:0]              op;
   logic [O_A_NUM_BITS-1:0] user, pass, item;
   logic [U_NUM_BITS-1:0]   perms, stock;
   logic [1:0]              step;
   logic [3:0]              wcnt;
   logic [3:0]              status_nx;
   logic                    match;
   logic [3:0]              dec_status;
   step_t                   cur;

   function automatic step_t step_of(input logic [2:0] op_v, input logic [1:0] s);
      step_t t;
      t = '{W_CMD, R_CMD, 1'b1};
      case (op_v)
         OP_LOGIN: case (s)
            2'd0:    t = '{W_CMD,  R_USRNAME, 1'b0};
            2'd1:    t = '{W_USER, R_PASSWD,  1'b0};
            default: t = '{W_PASS, R_CMD,     1'b1};
         endcase
         OP_ADD_USER: case (s)
            2'd0:    t = '{W_CMD,   R_USRNAME, 1'b0};
            2'd1:    t = '{W_USER,  R_PASSWD,  1'b0};
            2'd2:    t = '{W_PASS,  R_PERMS,   1'b0};
            default: t = '{W_PERMS, R_CMD,     1'b1};
         endcase
         OP_DEL_USER: t = (s == 2'd0) ? '{W_CMD, R_USRNAME, 1'b0} : '{W_USER, R_USRDELETD, 1'b1};
         OP_ADD_ITEM: case (s)
            2'd0:    t = '{W_CMD,   R_ITMNAME,  1'b0};
            2'd1:    t = '{W_ITEM,  R_STOCK,    1'b0};
            default: t = '{W_STOCK, R_ITMADDED, 1'b1};
         endcase
         OP_DEL_ITEM: t = (s == 2'd0) ? '{W_CMD, R_ITMNAME, 1'b0} : '{W_ITEM, R_ITMDELETD, 1'b1};
         OP_BUY:      t = (s == 2'd0) ? '{W_CMD, R_ITMNAME, 1'b0} : '{W_ITEM, R_ITMBOUGHT, 1'b1};
         default: ;
      endcase
      return t;
   endfunction

   assign cur = step_of(op, step);

   shop_resp_decode u_decode (
      .reply      (i_a),
      .expect_idx (cur.resp),
      .match      (match),
      .status     (dec_status)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= S_IDLE;
         op       <= '0;
         user     <= '0;
         pass     <= '0;
         item     <= '0;
         perms    <= '0;
         stock    <= '0;
         step     <= '0;
         wcnt     <= '0;
         o_status <= ST_OK;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: if (i_start) begin
               op    <= i_op;
               user  <= i_user;
               pass  <= i_pass;
               item  <= i_item;
               perms <= i_perms;
               stock <= i_stock;
               step  <= '0;
            end
            S_SEND:  wcnt <= '0;
            S_WAIT:  wcnt <= wcnt + 4'd1;
            S_CHECK: if (match && !cur.last) step <= step + 2'd1;
            default: ;
         endcase
         // Status is registered on entry to DONE so it is valid alongside o_done.
         if (state_nx == S_DONE) o_status <= status_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      status_nx = ST_OK;
      o_a       = '0;
      o_u       = '0;
      o_rdy     = 1'b0;
      case (state)
         S_IDLE: if (i_start) state_nx = S_SEND;
         S_SEND: begin
            if (op == OP_RSVD) begin
               state_nx  = S_DONE;
               status_nx = ST_BAD_OP;
            end else begin
               o_rdy = 1'b1;
               case (cur.word)
                  W_CMD:   o_a = cmd_str(op);
                  W_USER:  o_a = user;
                  W_PASS:  o_a = pass;
                  W_ITEM:  o_a = item;
                  W_PERMS: o_u = perms;
                  W_STOCK: o_u = stock;
                  default: ;
               endcase
               state_nx = (RESP_LAT == 1) ? S_CHECK : S_WAIT;
            end
         end
         // CHECK is the last of the RESP_LAT cycles, so WAIT covers RESP_LAT-1 of them.
         S_WAIT: if (wcnt == 4'(RESP_LAT - 2)) state_nx = S_CHECK;
         S_CHECK: begin
            if (match && !cur.last) begin
               state_nx = S_SEND;
            end else begin
               state_nx  = S_DONE;
               status_nx = match ? ST_OK : dec_status;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign o_busy = (state != S_IDLE);
   assign o_done = (state == S_DONE);

endmodule

// File: tb/tb_shop_client.sv
// tb/tb_shop_client.sv - table-driven bench for shop_client with a fixed-latency responder
module tb_shop_client;

   localparam int LAT = 3;

   localparam logic [2:0] OPC_LOGOUT = 3'd0, OPC_LOGIN = 3'd1, OPC_ADD_USER = 3'd2, OPC_DEL_USER = 3'd3;
   localparam logic [2:0] OPC_ADD_ITEM = 3'd4, OPC_DEL_ITEM = 3'd5, OPC_BUY = 3'd6, OPC_RSVD = 3'd7;

   localparam logic [55:0] N = '0;
   localparam logic [55:0] W_LOGOUT = 56'("Logout"), W_LOGIN = 56'("Login"), W_ADDUSR = 56'("AddUsr");
   localparam logic [55:0] W_DELUSR = 56'("DelUsr"), W_ADDITEM = 56'("AddItem"), W_DELITEM = 56'("DelItem");
   localparam logic [55:0] W_BUY = 56'("Buy"), BOB = 56'("Bob"), PW1 = 56'("pw1"), PEN = 56'("Pen");
   localparam logic [55:0] ALICE = 56'("alice"), SECRET = 56'("secret");

   localparam logic [71:0] Z = '0;
   localparam logic [71:0] R_CMD = 72'("Cmd?"), R_UNM = 72'("Usrname?"), R_PWD = 72'("Passwd?");
   localparam logic [71:0] R_PRM = 72'("Perms?"), R_UDEL = 72'("UsrDeletd"), R_INM = 72'("ItmName?");
   localparam logic [71:0] R_STK = 72'("Stock?"), R_IADD = 72'("ItmAdded"), R_IDEL = 72'("ItmDeletd");
   localparam logic [71:0] R_IBGT = 72'("ItmBought"), R_INVC = 72'("InvalCmd"), R_INVP = 72'("InvalPerm");
   localparam logic [71:0] R_UUNK = 72'("UsrUnknwn"), R_UTKN = 72'("UsrTaken"), R_NDA = 72'("NoDelAdmn");
   localparam logic [71:0] R_IFUL = 72'("ItmsFull"), R_IEX = 72'("ItmExists"), R_IUNK = 72'("ItmUnknwn");
   localparam logic [71:0] R_NYI = 72'("NtYourItm"), R_NOST = 72'("NoStock");

   typedef struct {
      logic [2:0]       op;
      logic [55:0]      user;
      logic [55:0]      pass;
      logic [3:0][71:0] rep;
      logic [3:0][55:0] ea;
      int               eu_step;
      logic [3:0]       eu_val;
      int               nrdy;
      int               done_cyc;
      logic [3:0]       st;
   } vec_t;

   logic        clk, i_reset, i_start;
   logic [2:0]  i_op;
   logic [55:0] i_user, i_pass, i_item;
   logic [3:0]  i_perms, i_stock;
   logic [55:0] o_a;
   logic        o_rdy;
   logic [3:0]  o_u;
   logic [71:0] i_a;
   logic        o_busy, o_done;
   logic [3:0]  o_status;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[$];

   shop_client #(.RESP_LAT(LAT)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
      .i_user(i_user), .i_pass(i_pass), .i_item(i_item), .i_perms(i_perms), .i_stock(i_stock),
      .o_a(o_a), .o_rdy(o_rdy), .o_u(o_u), .i_a(i_a),
      .o_busy(o_busy), .o_done(o_done), .o_status(o_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] op, input logic [55:0] user, input logic [55:0] pass,
                      input logic [71:0] r0, input logic [71:0] r1, input logic [71:0] r2, input logic [71:0] r3,
                      input logic [55:0] a0, input logic [55:0] a1, input logic [55:0] a2, input logic [55:0] a3,
                      input int eu_step, input logic [3:0] eu_val, input int nrdy, input int done_cyc,
                      input logic [3:0] st);
      vec_t v;
      v.op = op; v.user = user; v.pass = pass;
      v.rep[0] = r0; v.rep[1] = r1; v.rep[2] = r2; v.rep[3] = r3;
      v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
      v.eu_step = eu_step; v.eu_val = eu_val; v.nrdy = nrdy; v.done_cyc = done_cyc; v.st = st;
      vecs.push_back(v);
   endtask

   // Runs one table vector; optionally pulses a stray start mid-flight or in the done cycle.
   task automatic run(input int vi, input int extra_at, input bit start_in_done);
      vec_t        v;
      int          c, nr, rep_at;
      logic [71:0] rep_val;
      logic [1:0]  k;
      logic [3:0]  exp_u;
      bit          prev, got, zero_err;
      v = vecs[vi];
      i_op = v.op; i_user = v.user; i_pass = v.pass; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      c = 1; nr = 0; rep_at = -1; rep_val = '0; prev = 0; got = 0; zero_err = 0;
      while (c < 100) begin
         if (o_done) begin
            got = 1;
            chk($sformatf("v%0d done_cycle", vi), 72'(c), 72'(v.done_cyc));
            chk($sformatf("v%0d status", vi), 72'(o_status), 72'(v.st));
            chk($sformatf("v%0d busy_at_done", vi), 72'(o_busy), 72'(1));
            break;
         end
         if (c == extra_at) begin
            i_start = 1'b1;
            i_op    = OPC_LOGOUT;
         end else begin
            i_start = 1'b0;
         end
         if (o_rdy) begin
            if (prev) zero_err = 1;
            if (nr < 4) begin
               k = nr[1:0];
               exp_u = (nr == v.eu_step) ? v.eu_val : 4'd0;
               chk($sformatf("v%0d word%0d", vi, nr), 72'(o_a), 72'(v.ea[k]));
               chk($sformatf("v%0d num%0d", vi, nr), 72'(o_u), 72'(exp_u));
               chk($sformatf("v%0d rdy_cycle%0d", vi, nr), 72'(c), 72'(1 + nr * (LAT + 1)));
               rep_at  = c + LAT;
               rep_val = v.rep[k];
            end
            nr++;
         end else if (o_a != '0 || o_u != '0) begin
            zero_err = 1;
         end
         prev = o_rdy;
         i_a = (c == rep_at) ? rep_val : '0;
         tick();
         c++;
      end
      i_a = '0;
      i_start = 1'b0;
      if (!got) chk($sformatf("v%0d timeout_no_done", vi), 72'(0), 72'(1));
      chk($sformatf("v%0d rdy_count", vi), 72'(nr), 72'(v.nrdy));
      chk($sformatf("v%0d quiet_outside_send", vi), 72'(zero_err), 72'(0));
      if (start_in_done) begin
         i_start = 1'b1;
         i_op    = OPC_LOGOUT;
      end
      tick();
      i_start = 1'b0;
      chk($sformatf("v%0d done_one_cycle", vi), 72'(o_done), 72'(0));
      chk($sformatf("v%0d idle_after_done", vi), 72'(o_busy), 72'(0));
      chk($sformatf("v%0d status_held", vi), 72'(o_status), 72'(v.st));
   endtask

   initial begin
      bit done_seen;
      i_reset = 1'b1; i_start = 1'b0; i_op = '0; i_user = '0; i_pass = '0;
      i_item = PEN; i_perms = 4'd5; i_stock = 4'd9; i_a = '0;
      repeat (3) tick();
      chk("reset o_a", 72'(o_a), 72'(0));
      chk("reset o_rdy", 72'(o_rdy), 72'(0));
      chk("reset o_u", 72'(o_u), 72'(0));
      chk("reset o_busy", 72'(o_busy), 72'(0));
      chk("reset o_done", 72'(o_done), 72'(0));
      chk("reset o_status", 72'(o_status), 72'(0));
      i_reset = 1'b0;
      tick();

      add(OPC_LOGOUT,   BOB, PW1, R_CMD, Z, Z, Z,           W_LOGOUT, N, N, N,        -1, 4'd0, 1, 5,  4'd0);
      add(OPC_ADD_USER, BOB, PW1, R_UNM, R_PWD, R_PRM, R_CMD, W_ADDUSR, BOB, PW1, N,  3, 4'd5, 4, 17, 4'd0);
      add(OPC_BUY,      BOB, PW1, R_INM, R_NOST, Z, Z,      W_BUY, PEN, N, N,         -1, 4'd0, 2, 9,  4'd10);
      add(OPC_LOGIN,    BOB, PW1, R_CMD, Z, Z, Z,           W_LOGIN, N, N, N,         -1, 4'd0, 1, 5,  4'd15);
      add(OPC_RSVD,     BOB, PW1, Z, Z, Z, Z,               N, N, N, N,               -1, 4'd0, 0, 2,  4'd14);
      add(OPC_LOGIN,    ALICE, SECRET, R_UNM, R_PWD, R_CMD, Z, W_LOGIN, ALICE, SECRET, N, -1, 4'd0, 3, 13, 4'd0);
      add(OPC_DEL_USER, BOB, PW1, R_UNM, R_UUNK, Z, Z,      W_DELUSR, BOB, N, N,      -1, 4'd0, 2, 9,  4'd3);
      add(OPC_ADD_ITEM, BOB, PW1, R_INM, R_STK, R_IADD, Z,  W_ADDITEM, PEN, N, N,     2, 4'd9, 3, 13, 4'd0);
      add(OPC_DEL_ITEM, BOB, PW1, R_INM, R_NYI, Z, Z,       W_DELITEM, PEN, N, N,     -1, 4'd0, 2, 9,  4'd9);
      add(OPC_ADD_USER, BOB, PW1, R_INVP, Z, Z, Z,          W_ADDUSR, N, N, N,        -1, 4'd0, 1, 5,  4'd2);
      add(OPC_ADD_ITEM, BOB, PW1, R_IFUL, Z, Z, Z,          W_ADDITEM, N, N, N,       -1, 4'd0, 1, 5,  4'd6);
      add(OPC_LOGIN,    BOB, PW1, R_INVC, Z, Z, Z,          W_LOGIN, N, N, N,         -1, 4'd0, 1, 5,  4'd1);
      add(OPC_DEL_ITEM, BOB, PW1, R_INM, R_IUNK, Z, Z,      W_DELITEM, PEN, N, N,     -1, 4'd0, 2, 9,  4'd8);
      add(OPC_ADD_USER, BOB, PW1, R_UNM, R_UTKN, Z, Z,      W_ADDUSR, BOB, N, N,      -1, 4'd0, 2, 9,  4'd4);
      add(OPC_DEL_USER, BOB, PW1, R_UNM, R_NDA, Z, Z,       W_DELUSR, BOB, N, N,      -1, 4'd0, 2, 9,  4'd5);
      add(OPC_ADD_ITEM, BOB, PW1, R_INM, R_IEX, Z, Z,       W_ADDITEM, PEN, N, N,     -1, 4'd0, 2, 9,  4'd7);
      add(OPC_DEL_USER, BOB, PW1, R_UNM, R_UDEL, Z, Z,      W_DELUSR, BOB, N, N,      -1, 4'd0, 2, 9,  4'd0);
      add(OPC_DEL_ITEM, BOB, PW1, R_INM, R_IDEL, Z, Z,      W_DELITEM, PEN, N, N,     -1, 4'd0, 2, 9,  4'd0);
      add(OPC_BUY,      BOB, PW1, R_INM, R_IBGT, Z, Z,      W_BUY, PEN, N, N,         -1, 4'd0, 2, 9,  4'd0);
      add(OPC_ADD_USER, BOB, PW1, R_UNM, R_PWD, R_CMD, Z,   W_ADDUSR, BOB, PW1, N,    -1, 4'd0, 3, 13, 4'd15);

      foreach (vecs[i]) run(i, (i == 17) ? 3 : -1, (i == 1));

      // Reset in the middle of an ADD_ITEM, with a non-zero status left from the last vector.
      i_op = OPC_ADD_ITEM; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int c = 1; c < 6; c++) begin
         i_a = (c == 4) ? R_INM : '0;
         tick();
      end
      i_a = '0;
      chk("midreset busy_before", 72'(o_busy), 72'(1));
      i_reset = 1'b1;
      tick();
      chk("midreset o_a", 72'(o_a), 72'(0));
      chk("midreset o_rdy", 72'(o_rdy), 72'(0));
      chk("midreset o_u", 72'(o_u), 72'(0));
      chk("midreset o_busy", 72'(o_busy), 72'(0));
      chk("midreset o_done", 72'(o_done), 72'(0));
      chk("midreset o_status", 72'(o_status), 72'(0));
      i_reset = 1'b0;
      done_seen = 0;
      repeat (20) begin
         if (o_done || o_rdy) done_seen = 1;
         tick();
      end
      chk("midreset no_done_after", 72'(done_seen), 72'(0));
      run(0, -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
